// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one outstanding fetch at a time and buffers
// returned words in a small FIFO. Branch redirects flush the FIFO and discard
// any response already in flight. The head word's opcode selects the
// immediate format for the downstream immediate generator.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [1:0]  imm_sel
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          run_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];

  logic          push;
  logic          pop;
  logic [31:0]   redirect_base;
  logic [31:0]   resp_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
  // The fetch PC only moves by +4 on a request or by a redirect, and a
  // redirect in WAIT suppresses the push, so the address of the response
  // being pushed is always the current PC minus 4.
  assign resp_pc       = pc_q - 32'd4;

  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = buf_instr[rd_ptr_q];
  assign instr_pc    = buf_pc[rd_ptr_q];
  assign pop         = instr_valid && instr_ready;

  // Next-state, request generation and PC update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push     = 1'b0;
    imem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        // run_q keeps the request low until the first clock after reset release
        if (run_q && (count_q < COUNT_FULL) && !redirect_valid) begin
          imem_req = 1'b1;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? S_IDLE : S_DROP;
        end else if (imem_rvalid) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        // The in-flight response is consumed here even if a new redirect
        // arrives with it, otherwise DROP would wait for a response that
        // never comes.
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_base;
    end
  end

  // State, PC and FIFO bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      run_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      run_q   <= 1'b1;
      if (redirect_valid) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        if (pop) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (!push && pop) begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr_q] <= imem_rdata;
      buf_pc[wr_ptr_q]    <= resp_pc;
    end
  end

  // Immediate format select from the head opcode
  always_comb begin
    imm_sel = 2'b00;
    case (instr_out[6:0])
      7'b0100011: imm_sel = 2'b01;
      7'b1100011: imm_sel = 2'b10;
      default:    imm_sel = 2'b00;
    endcase
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset (bits [1:0] SHALL be 0).
REQ-002 SHALL provide parameter: DEPTH, 2, instruction buffer entries (fixed at 2 for this revision).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: imem_req  output  1  fetch request to instruction memory, accepted in the cycle it is high.
REQ-006 SHALL have port: imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-007 SHALL have port: imem_rvalid  input  1  read data valid, exactly one pulse per accepted request, at least 1 cycle after it.
REQ-008 SHALL have port: imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-009 SHALL have port: redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port: redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-011 SHALL have port: instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port: instr_ready  input  1  decode/immediate stage consumes head when instr_valid=1.
REQ-013 SHALL have port: instr_out  output  32  head instruction word, feeds the immediate generator's instruction input.
REQ-014 SHALL have port: instr_pc  output  32  address of instr_out.
REQ-015 SHALL have port: imm_sel  output  2  immediate format select for the immediate generator, decoded from instr_out[6:0].

Function
REQ-016 SHALL keep a 32-bit fetch PC, a 2-entry FIFO of {instr, pc}, and a 3-state FSM: IDLE, WAIT, DROP.
REQ-017 SHALL, in IDLE, drive imem_req=1 and imem_addr=PC when FIFO count < DEPTH and redirect_valid=0; otherwise imem_req=0.
REQ-018 SHALL, on a request, advance PC by 4 (modulo 2^32: 32'hFFFF_FFFC wraps to 0) and enter WAIT; at most one request outstanding.
REQ-019 SHALL, in WAIT, hold imem_req=0; on imem_rvalid push {imem_rdata, request address} into FIFO and return to IDLE.
REQ-020 SHALL make a pushed entry visible on instr_valid/instr_out/instr_pc the cycle after imem_rvalid (1-cycle latency); peak rate one instruction per 2 cycles.
REQ-021 SHALL drive instr_valid = FIFO not empty, directly from registered state; instr_out/instr_pc from FIFO head; contents don't-care when instr_valid=0.
REQ-022 SHALL pop the head on instr_valid & instr_ready; simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.
REQ-023 SHALL never overflow: request gating guarantees count + outstanding <= DEPTH; a full FIFO with instr_ready=0 stalls fetch indefinitely without loss.
REQ-024 SHALL, on redirect_valid in any state, empty the FIFO (overriding same-cycle push/pop) and load PC with {redirect_pc[31:2], 2'b00}.
REQ-025 SHALL, on redirect in WAIT without imem_rvalid, enter DROP; with same-cycle imem_rvalid, discard the response and enter IDLE.
REQ-026 SHALL, in DROP, hold imem_req=0, discard the next imem_rvalid and return to IDLE; a further redirect in DROP updates PC and stays in DROP.
REQ-027 SHALL ignore imem_rvalid in IDLE (no request outstanding).
REQ-028 SHALL decode imm_sel combinationally: 7'b0100011 (store) -> 2'b01; 7'b1100011 (branch) -> 2'b10; all other opcodes (loads, OP-IMM, JALR, others) -> 2'b00.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force state=IDLE, PC=RESET_PC, FIFO empty, imem_req=0, instr_valid=0; imem_addr, instr_out, instr_pc, imm_sel are don't-care.
REQ-030 SHALL, on the first rising clk edge with rst_n=1, present imem_req=1, imem_addr=RESET_PC in that cycle.
REQ-031 SHALL, on reset asserted mid-operation (WAIT or DROP), abandon the outstanding request; a later imem_rvalid before the first new request is ignored.

Verification
REQ-032 SHALL cover: reset release, rvalid 1 cycle after each req, instr_ready=1, rdata 0x00500093/0x00208023/0xFE000EE3 -> instr_pc 0x0,0x4,0x8, imm_sel 00,01,10.
REQ-033 SHALL cover: instr_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req low after 2nd response, PCs 0x0,0x4 delivered in order once ready rises.
REQ-034 SHALL cover: redirect_pc=0x103 during WAIT, rvalid 3 cycles later -> response dropped, next imem_addr=0x100, no stale instr_valid.
REQ-035 SHALL cover: redirect coincident with imem_rvalid and instr_ready while FIFO holds 1 entry -> FIFO empty next cycle, next fetch at redirect address.
REQ-036 SHALL cover: RESET_PC=0xFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-037 SHALL cover: rst_n low in WAIT, released, then late rvalid -> ignored, first request at RESET_PC.
